// File: rtl/memctl_pkg.sv
// Shared types and parameter-derivation helpers for the banked A/D/M memory controller.
package memctl_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } state_t;

  // Wide enough to hold the largest supported read latency (4).
  localparam int CNT_W = 3;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int bank_bits(input int num_banks);
    return (num_banks > 1) ? clog2(num_banks) : 1;
  endfunction

  function automatic int bank_aw(input int addr_w, input int num_banks);
    return addr_w - bank_bits(num_banks);
  endfunction

endpackage

// File: rtl/memctl_rd_pipe.sv
// RD_LAT-deep delay line of {valid, bank}. It follows each BRAM read to the cycle its data
// appears on bram_douta, so the top level can pick the right bank and ignore aborted reads.
module memctl_rd_pipe #(
  parameter int DEPTH     = 1,
  parameter int BANK_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [BANK_BITS-1:0] in_bank,
  output logic                 out_valid,
  output logic [BANK_BITS-1:0] out_bank
);

  logic                 valid_q [DEPTH];
  logic [BANK_BITS-1:0] bank_q  [DEPTH];

  // NOTE: sequential state uses non-blocking (<=) so every stage samples its neighbour's old value.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
    end else begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  // NOTE: only the valid bits need reset; a bank index is never looked at while its valid bit is 0.
  always_ff @(posedge clk) begin
    bank_q[0] <= in_bank;
    for (int i = 1; i < DEPTH; i++) bank_q[i] <= bank_q[i-1];
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_bank  = bank_q[DEPTH-1];

endmodule

// File: rtl/banked_memory_controller.sv
// A/D/M register file and banked BRAM front end; M is fetched with explicit read-latency tracking.
// Optional MEMCTL_OOR_FLAG_EN adds a sticky oor_err output for out-of-range bank accesses.
module banked_memory_controller
  import memctl_pkg::*;
#(
  parameter int  DATA_W    = 16,
  parameter int  ADDR_W    = 16,
  parameter int  NUM_BANKS = 2,
  parameter int  RD_LAT    = 1,
  localparam int BANK_BITS = bank_bits(NUM_BANKS),
  localparam int BANK_AW   = bank_aw(ADDR_W, NUM_BANKS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        reg_a_en,
  input  logic                        reg_d_en,
  input  logic                        reg_m_en,
  input  logic [DATA_W-1:0]           data_in,
  output logic [DATA_W-1:0]           reg_a_out,
  output logic [DATA_W-1:0]           reg_d_out,
  output logic [DATA_W-1:0]           reg_m_out,
  output logic                        m_valid,
  output logic                        busy,
  output logic [NUM_BANKS-1:0]        bram_en,
  output logic [NUM_BANKS-1:0]        bram_wea,
  output logic [BANK_AW-1:0]          bram_addra,
  output logic [DATA_W-1:0]           bram_dina,
  input  logic [NUM_BANKS*DATA_W-1:0] bram_douta
`ifdef MEMCTL_OOR_FLAG_EN
  ,
  output logic                        oor_err
`endif
);

  state_t               state_q, state_d;
  logic                 pend_q, pend_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 do_issue, do_capture, flush;
  logic [ADDR_W-1:0]    issue_addr;
  logic [ADDR_W-1:0]    a_addr;
  logic                 rd_q;
  logic [BANK_BITS-1:0] bank_q;
  logic                 pipe_valid;
  logic [BANK_BITS-1:0] pipe_bank;
  logic [DATA_W-1:0]    rd_data;

  assign a_addr = reg_a_out[ADDR_W-1:0];

  function automatic logic [BANK_BITS-1:0] bank_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: BANK_BITS];
  endfunction

  function automatic logic in_range(input logic [BANK_BITS-1:0] b);
    return int'(b) < NUM_BANKS;
  endfunction

  function automatic logic [NUM_BANKS-1:0] one_hot(input logic [ADDR_W-1:0] addr);
    logic [NUM_BANKS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (int'(bank_of(addr)) == i) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  // pend marks a fetch of the current A that still has to be launched: after reset, and after a
  // write that shared its edge with a new A (the port was busy with the write that cycle).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d    = state_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    do_issue   = 1'b0;
    do_capture = 1'b0;
    flush      = 1'b0;
    issue_addr = a_addr;
    if (reg_m_en) begin
      flush = 1'b1;
      if (reg_a_en) begin
        state_d = ST_FETCH;
        pend_d  = 1'b1;
      end else begin
        state_d = ST_IDLE;
        pend_d  = 1'b0;
      end
    end else if (reg_a_en) begin
      flush      = 1'b1;
      do_issue   = 1'b1;
      issue_addr = data_in[ADDR_W-1:0];
      state_d    = ST_FETCH;
      pend_d     = 1'b0;
      cnt_d      = CNT_W'(RD_LAT);
    end else if (state_q == ST_FETCH) begin
      if (pend_q) begin
        do_issue = 1'b1;
        pend_d   = 1'b0;
        cnt_d    = CNT_W'(RD_LAT);
      end else if (cnt_q == '0) begin
        do_capture = 1'b1;
        state_d    = ST_IDLE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pend_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    m_valid = (state_q == ST_IDLE);
    busy    = (state_q == ST_FETCH);
  end

  always_comb begin
    rd_data = '0;
    if (pipe_valid && in_range(pipe_bank)) begin
      rd_data = bram_douta[int'(pipe_bank)*DATA_W +: DATA_W];
    end
  end

  // BRAM enables are single-cycle pulses; address and write data hold between accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_a_out  <= '0;
      reg_d_out  <= '0;
      reg_m_out  <= '0;
      bram_en    <= '0;
      bram_wea   <= '0;
      bram_addra <= '0;
      bram_dina  <= '0;
      rd_q       <= 1'b0;
      bank_q     <= '0;
    end else begin
      bram_en  <= '0;
      bram_wea <= '0;
      rd_q     <= 1'b0;
      if (reg_d_en) reg_d_out <= data_in;
      if (reg_a_en) reg_a_out <= data_in;
      if (reg_m_en) begin
        bram_en    <= one_hot(a_addr);
        bram_wea   <= one_hot(a_addr);
        bram_addra <= a_addr[BANK_AW-1:0];
        bram_dina  <= data_in;
        if (!reg_a_en) reg_m_out <= data_in;
      end else if (do_issue) begin
        bram_en    <= one_hot(issue_addr);
        bram_addra <= issue_addr[BANK_AW-1:0];
        rd_q       <= 1'b1;
        bank_q     <= bank_of(issue_addr);
      end
      if (do_capture) reg_m_out <= rd_data;
    end
  end

  memctl_rd_pipe #(
    .DEPTH     (RD_LAT),
    .BANK_BITS (BANK_BITS)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (rd_q),
    .in_bank   (bank_q),
    .out_valid (pipe_valid),
    .out_bank  (pipe_bank)
  );

`ifdef MEMCTL_OOR_FLAG_EN
  logic oor_hit;
  assign oor_hit = (reg_m_en && !in_range(bank_of(a_addr)))
                || (do_issue && !in_range(bank_of(issue_addr)));

  always_ff @(posedge clk) begin
    if (rst)          oor_err <= 1'b0;
    else if (oor_hit) oor_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_banked_memory_controller.sv
// Self-checking bench for banked_memory_controller: 3 banks, read latency 3, behavioural BRAM
// and a reference memory image the bench updates from its own writes.
module tb_banked_memory_controller;

  localparam int NB = 3;
  localparam int RL = 3;
  localparam int MD = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            reg_a_en, reg_d_en, reg_m_en;
  logic [15:0]     data_in;
  logic [15:0]     reg_a_out, reg_d_out, reg_m_out;
  logic            m_valid, busy;
  logic [NB-1:0]   bram_en, bram_wea;
  logic [13:0]     bram_addra;
  logic [15:0]     bram_dina;
  logic [NB*16-1:0] bram_douta;
`ifdef MEMCTL_OOR_FLAG_EN
  logic            oor_err;
`endif

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [15:0] ref_mem  [NB][MD];
  logic [15:0] bram_mem [NB][MD];
  logic [15:0] bram_rd  [NB][RL];
  logic        load_req = 1'b0;
  logic [15:0] cur_a;
  logic [15:0] exp_d;

  banked_memory_controller #(
    .DATA_W    (16),
    .ADDR_W    (16),
    .NUM_BANKS (NB),
    .RD_LAT    (RL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .reg_a_en   (reg_a_en),
    .reg_d_en   (reg_d_en),
    .reg_m_en   (reg_m_en),
    .data_in    (data_in),
    .reg_a_out  (reg_a_out),
    .reg_d_out  (reg_d_out),
    .reg_m_out  (reg_m_out),
    .m_valid    (m_valid),
    .busy       (busy),
    .bram_en    (bram_en),
    .bram_wea   (bram_wea),
    .bram_addra (bram_addra),
    .bram_dina  (bram_dina),
    .bram_douta (bram_douta)
`ifdef MEMCTL_OOR_FLAG_EN
    ,
    .oor_err    (oor_err)
`endif
  );

  always #5 clk = ~clk;

  // Single-port BRAM per bank: write on en&wea, registered read with RL output stages.
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (load_req) begin
        for (int i = 0; i < MD; i++) bram_mem[b][i] <= ref_mem[b][i];
        for (int s = 0; s < RL; s++) bram_rd[b][s] <= '0;
      end else begin
        if (bram_en[b] && bram_wea[b]) bram_mem[b][bram_addra[5:0]] <= bram_dina;
        else if (bram_en[b])           bram_rd[b][0] <= bram_mem[b][bram_addra[5:0]];
        for (int s = 1; s < RL; s++) bram_rd[b][s] <= bram_rd[b][s-1];
      end
    end
  end

  always_comb begin
    bram_douta = '0;
    for (int b = 0; b < NB; b++) bram_douta[b*16 +: 16] = bram_rd[b][RL-1];
  end

  function automatic logic [15:0] ref_read(input logic [15:0] addr);
    int b;
    b = int'(addr[15:14]);
    if (b >= NB) return 16'h0000;
    return ref_mem[b][addr[5:0]];
  endfunction

  function automatic logic [NB-1:0] exp_en_of(input logic [15:0] addr);
    logic [NB-1:0] e;
    e = '0;
    if (int'(addr[15:14]) < NB) e[addr[15:14]] = 1'b1;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    tests_run++; if (reg_a_out !== 16'h0) begin tests_failed++; $display("FAIL %s A: got %h want 0000", tag, reg_a_out); end
    tests_run++; if (reg_d_out !== 16'h0) begin tests_failed++; $display("FAIL %s D: got %h want 0000", tag, reg_d_out); end
    tests_run++; if (reg_m_out !== 16'h0) begin tests_failed++; $display("FAIL %s M: got %h want 0000", tag, reg_m_out); end
    tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL %s m_valid: got %b want 0", tag, m_valid); end
    tests_run++; if (bram_en !== '0) begin tests_failed++; $display("FAIL %s bram_en: got %b want 0", tag, bram_en); end
    tests_run++; if (bram_wea !== '0) begin tests_failed++; $display("FAIL %s bram_wea: got %b want 0", tag, bram_wea); end
    tests_run++; if (bram_addra !== '0) begin tests_failed++; $display("FAIL %s bram_addra: got %h want 0", tag, bram_addra); end
`ifdef MEMCTL_OOR_FLAG_EN
    tests_run++; if (oor_err !== 1'b0) begin tests_failed++; $display("FAIL %s oor_err: got %b want 0", tag, oor_err); end
`endif
  endtask

  // After reset release the controller fetches address 0; M is valid RL+2 edges later.
  task automatic check_release(input string tag);
    int n;
    rst = 1'b0;
    n = 0;
    while (!m_valid && n < 20) begin tick(); n++; end
    tests_run++; if (n !== RL + 2) begin tests_failed++; $display("FAIL %s release latency: got %0d want %0d", tag, n, RL + 2); end
    tests_run++; if (reg_m_out !== ref_read(16'h0000)) begin tests_failed++; $display("FAIL %s M: got %h want %h", tag, reg_m_out, ref_read(16'h0000)); end
    cur_a = 16'h0000;
  endtask

  task automatic do_fetch(input logic [15:0] addr, input string tag);
    int n;
    data_in  = addr;
    reg_a_en = 1'b1;
    tick();
    reg_a_en = 1'b0;
    cur_a    = addr;
    tests_run++; if (reg_a_out !== addr) begin tests_failed++; $display("FAIL %s A: got %h want %h", tag, reg_a_out, addr); end
    tests_run++; if (bram_en !== exp_en_of(addr)) begin tests_failed++; $display("FAIL %s bram_en: got %b want %b", tag, bram_en, exp_en_of(addr)); end
    if (exp_en_of(addr) != '0) begin
      tests_run++; if (bram_addra !== addr[13:0]) begin tests_failed++; $display("FAIL %s bram_addra: got %h want %h", tag, bram_addra, addr[13:0]); end
    end
    n = 0;
    while (!m_valid && n < 20) begin
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL %s busy: got %b want 1", tag, busy); end
      tick();
      n++;
    end
    tests_run++; if (n !== RL + 1) begin tests_failed++; $display("FAIL %s latency: got %0d want %0d", tag, n, RL + 1); end
    tests_run++; if (reg_m_out !== ref_read(addr)) begin tests_failed++; $display("FAIL %s M: got %h want %h", tag, reg_m_out, ref_read(addr)); end
  endtask

  task automatic do_write(input logic [15:0] data, input string tag);
    logic in_rng;
    in_rng   = (int'(cur_a[15:14]) < NB);
    data_in  = data;
    reg_m_en = 1'b1;
    tick();
    reg_m_en = 1'b0;
    tests_run++; if (bram_wea !== exp_en_of(cur_a)) begin tests_failed++; $display("FAIL %s bram_wea: got %b want %b", tag, bram_wea, exp_en_of(cur_a)); end
    tests_run++; if (bram_en !== exp_en_of(cur_a)) begin tests_failed++; $display("FAIL %s bram_en: got %b want %b", tag, bram_en, exp_en_of(cur_a)); end
    tests_run++; if (m_valid !== 1'b1) begin tests_failed++; $display("FAIL %s m_valid: got %b want 1", tag, m_valid); end
    if (in_rng) begin
      tests_run++; if (bram_addra !== cur_a[13:0]) begin tests_failed++; $display("FAIL %s bram_addra: got %h want %h", tag, bram_addra, cur_a[13:0]); end
      tests_run++; if (bram_dina !== data) begin tests_failed++; $display("FAIL %s bram_dina: got %h want %h", tag, bram_dina, data); end
      tests_run++; if (reg_m_out !== data) begin tests_failed++; $display("FAIL %s M: got %h want %h", tag, reg_m_out, data); end
      ref_mem[cur_a[15:14]][cur_a[5:0]] = data;
    end
    tick();
    tests_run++; if (bram_wea !== '0) begin tests_failed++; $display("FAIL %s wea pulse: got %b want 0", tag, bram_wea); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    check_reset_values("reset");
    check_release("reset_release");
  endtask

  task automatic test_fetch();
    do_fetch(16'h8005, "fetch_8005");
    do_fetch(16'h4011, "fetch_4011");
    do_fetch(16'h0005, "fetch_0005");
  endtask

  task automatic test_write();
    do_fetch(16'h0003, "write_pre");
    do_write(16'hBEEF, "write_beef");
    do_fetch(16'h0003, "write_refetch");
  endtask

  task automatic test_a_and_m_same_edge();
    int n;
    do_fetch(16'h0002, "am_pre");
    data_in  = 16'h8002;
    reg_a_en = 1'b1;
    reg_m_en = 1'b1;
    tick();
    reg_a_en = 1'b0;
    reg_m_en = 1'b0;
    tests_run++; if (bram_wea !== 3'b001) begin tests_failed++; $display("FAIL am bram_wea: got %b want 001", bram_wea); end
    tests_run++; if (bram_addra !== 14'h0002) begin tests_failed++; $display("FAIL am bram_addra: got %h want 0002", bram_addra); end
    tests_run++; if (bram_dina !== 16'h8002) begin tests_failed++; $display("FAIL am bram_dina: got %h want 8002", bram_dina); end
    tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL am m_valid: got %b want 0", m_valid); end
    tests_run++; if (reg_a_out !== 16'h8002) begin tests_failed++; $display("FAIL am A: got %h want 8002", reg_a_out); end
    ref_mem[0][2] = 16'h8002;
    cur_a = 16'h8002;
    n = 0;
    while (!m_valid && n < 20) begin tick(); n++; end
    tests_run++; if (n >= 20) begin tests_failed++; $display("FAIL am fetch timeout: got %0d cycles want <20", n); end
    tests_run++; if (reg_m_out !== ref_read(16'h8002)) begin tests_failed++; $display("FAIL am M: got %h want %h", reg_m_out, ref_read(16'h8002)); end
    do_fetch(16'h0002, "am_refetch_old");
  endtask

  task automatic test_abort();
    int n;
    data_in  = 16'h400A;
    reg_a_en = 1'b1;
    tick();
    reg_a_en = 1'b0;
    tick();
    data_in  = 16'h8014;
    reg_a_en = 1'b1;
    tick();
    reg_a_en = 1'b0;
    cur_a    = 16'h8014;
    n = 0;
    while (!m_valid && n < 20) begin
      tests_run++; if (reg_m_out === 16'hA1A1) begin tests_failed++; $display("FAIL abort stale M: got %h want not A1A1", reg_m_out); end
      tick();
      n++;
    end
    tests_run++; if (n !== RL + 1) begin tests_failed++; $display("FAIL abort latency: got %0d want %0d", n, RL + 1); end
    tests_run++; if (reg_m_out !== 16'hB2B2) begin tests_failed++; $display("FAIL abort M: got %h want B2B2", reg_m_out); end
    repeat (RL + 2) begin
      tick();
      tests_run++; if (reg_m_out !== 16'hB2B2) begin tests_failed++; $display("FAIL abort M hold: got %h want B2B2", reg_m_out); end
    end
  endtask

  task automatic test_random();
    logic [15:0] addr;
    logic [15:0] data;
    for (int it = 0; it < 40; it++) begin
      reg_d_en = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 2))
        0: begin
          addr = {2'(($urandom_range(0, NB - 1))), 8'h00, 6'($urandom_range(0, MD - 1))};
          do_fetch(addr, "rand_fetch");
          if (reg_d_en) exp_d = addr;
        end
        1: begin
          data = 16'($urandom);
          do_write(data, "rand_write");
          if (reg_d_en) exp_d = data;
        end
        default: begin
          data    = 16'($urandom);
          data_in = data;
          reg_d_en = 1'b1;
          tick();
          exp_d = data;
        end
      endcase
      reg_d_en = 1'b0;
      tests_run++; if (reg_d_out !== exp_d) begin tests_failed++; $display("FAIL rand D: got %h want %h", reg_d_out, exp_d); end
    end
  endtask

  task automatic test_oor();
`ifdef MEMCTL_OOR_FLAG_EN
    tests_run++; if (oor_err !== 1'b0) begin tests_failed++; $display("FAIL oor pre flag: got %b want 0", oor_err); end
`endif
    do_fetch(16'hC000, "oor_fetch");
`ifdef MEMCTL_OOR_FLAG_EN
    tests_run++; if (oor_err !== 1'b1) begin tests_failed++; $display("FAIL oor fetch flag: got %b want 1", oor_err); end
`endif
    do_write(16'h5555, "oor_write");
    do_fetch(16'h0001, "oor_after");
`ifdef MEMCTL_OOR_FLAG_EN
    tests_run++; if (oor_err !== 1'b1) begin tests_failed++; $display("FAIL oor sticky: got %b want 1", oor_err); end
`endif
  endtask

  task automatic test_reset_mid_fetch();
    data_in  = 16'h8007;
    reg_a_en = 1'b1;
    tick();
    reg_a_en = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check_reset_values("rst_mid_fetch");
    exp_d = 16'h0000;
    check_release("rst_mid_release");
  endtask

  initial begin
    rst      = 1'b1;
    reg_a_en = 1'b0;
    reg_d_en = 1'b0;
    reg_m_en = 1'b0;
    data_in  = 16'h0000;
    exp_d    = 16'h0000;
    cur_a    = 16'h0000;
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < MD; i++) ref_mem[b][i] = 16'($urandom);
    ref_mem[0][0]  = 16'h1234;
    ref_mem[2][5]  = 16'h5A5A;
    ref_mem[1][10] = 16'hA1A1;
    ref_mem[2][20] = 16'hB2B2;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;

    test_reset();
    test_fetch();
    test_write();
    test_a_and_m_same_edge();
    test_abort();
    test_random();
    test_oor();
    test_reset_mid_fetch();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
